// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, taken-branch flush and optional MDU hold.
// Define STALL_CTRL_MDU_EN to enable the MDU_BUSY state and the EX_mdu_start/mdu_done ports.
module stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_use_rs1,
  input  logic        ID_use_rs2,
  input  logic [4:0]  EX_rd,
  input  logic [4:0]  MEM_rd,
  input  logic        EX_MemRead,
  input  logic        MEM_MemRead,
  input  logic        EX_branch_taken,
  input  logic        EX_mdu_start,
  input  logic        mdu_done,
  output logic        PC_write,
  output logic        IFID_write,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EX_hold,
  output logic        EXMEM_flush,
  output logic [31:0] stall_count
);

`ifdef STALL_CTRL_MDU_EN
  typedef enum logic [1:0] {RUN = 2'd0, LD_STALL = 2'd1, MDU_BUSY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, LD_STALL = 2'd1} state_t;
  logic unused_mdu;
  assign unused_mdu = EX_mdu_start ^ mdu_done;
`endif

  // state is the observable FSM state for checkers and debug.
  state_t      state;
  state_t      state_nxt;
  logic        hz_ex;
  logic        hz_mem;
  logic [31:0] cnt_q;

  // Load data is only forwardable from WB: a load in EX needs two bubbles, in MEM one.
  assign hz_ex  = EX_MemRead && (EX_rd != 5'd0) &&
                  ((ID_use_rs1 && (ID_rs1 == EX_rd)) || (ID_use_rs2 && (ID_rs2 == EX_rd)));
  assign hz_mem = MEM_MemRead && (MEM_rd != 5'd0) &&
                  ((ID_use_rs1 && (ID_rs1 == MEM_rd)) || (ID_use_rs2 && (ID_rs2 == MEM_rd)));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EX_hold     = 1'b0;
    EXMEM_flush = 1'b0;
    case (state)
      RUN: begin
`ifdef STALL_CTRL_MDU_EN
        if (EX_mdu_start && !mdu_done) begin
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          EX_hold     = 1'b1;
          EXMEM_flush = 1'b1;
          state_nxt   = MDU_BUSY;
        end else
`endif
        if (EX_branch_taken) begin
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
        end else if (hz_ex) begin
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          IDEX_flush = 1'b1;
          state_nxt  = LD_STALL;
        end else if (hz_mem) begin
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          IDEX_flush = 1'b1;
        end
      end
      LD_STALL: begin
        PC_write   = 1'b0;
        IFID_write = 1'b0;
        IDEX_flush = 1'b1;
        state_nxt  = RUN;
      end
`ifdef STALL_CTRL_MDU_EN
      MDU_BUSY: begin
        // The done cycle itself is not a stall: EX releases and retires the result.
        if (!mdu_done) begin
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          EX_hold     = 1'b1;
          EXMEM_flush = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
`endif
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                              cnt_q <= 32'd0;
    else if (!PC_write && cnt_q != '1)    cnt_q <= cnt_q + 32'd1;
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: single-cycle vector table plus multi-cycle sequences
// (load-use, MDU hold, reset inside a stall, counter saturation).
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd, MEM_rd;
  logic        ID_use_rs1, ID_use_rs2, EX_MemRead, MEM_MemRead;
  logic        EX_branch_taken, EX_mdu_start, mdu_done;
  logic        PC_write, IFID_write, IFID_flush, IDEX_flush, EX_hold, EXMEM_flush;
  logic [31:0] stall_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt;

  // Output order: {PC_write, IFID_write, IFID_flush, IDEX_flush, EX_hold, EXMEM_flush}
  localparam logic [5:0] O_RUN = 6'b110000;
  localparam logic [5:0] O_LD  = 6'b000100;
  localparam logic [5:0] O_BR  = 6'b111100;
  localparam logic [5:0] O_MDU = 6'b000011;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, ex_rd, mem_rd;
    logic       use1, use2, ex_mr, mem_mr, br, mstart, mdone;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];

  stall_ctrl dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_rd(EX_rd), .MEM_rd(MEM_rd), .EX_MemRead(EX_MemRead), .MEM_MemRead(MEM_MemRead),
    .EX_branch_taken(EX_branch_taken), .EX_mdu_start(EX_mdu_start), .mdu_done(mdu_done),
    .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
    .IDEX_flush(IDEX_flush), .EX_hold(EX_hold), .EXMEM_flush(EXMEM_flush),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    EX_rd = 5'd0; MEM_rd = 5'd0; EX_MemRead = 1'b0; MEM_MemRead = 1'b0;
    EX_branch_taken = 1'b0; EX_mdu_start = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_use_rs1 = v.use1; ID_use_rs2 = v.use2;
    EX_rd = v.ex_rd; MEM_rd = v.mem_rd; EX_MemRead = v.ex_mr; MEM_MemRead = v.mem_mr;
    EX_branch_taken = v.br; EX_mdu_start = v.mstart; mdu_done = v.mdone;
  endtask

  task automatic check_cnt(input string name);
    n_vec++;
    if (stall_count !== exp_cnt) begin
      n_err++;
      $display("FAIL %s stall_count: got %h expected %h", name, stall_count, exp_cnt);
    end
  endtask

  // Called just after a negedge with inputs set: check outputs, clock once, check counter.
  task automatic step(input string name, input logic [5:0] exp);
    logic [5:0] got;
    #1;
    got = {PC_write, IFID_write, IFID_flush, IDEX_flush, EX_hold, EXMEM_flush};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s outputs: got %b expected %b", name, got, exp);
    end
    @(posedge clk);
    if (rst)                                   exp_cnt = 32'd0;
    else if (!exp[5] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    #1;
    check_cnt(name);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"idle",        5'd3, 5'd4, 5'd7, 5'd8, 1, 1, 0, 0, 0, 0, 0, O_RUN};
    vecs[1] = '{"hz_mem_rs2",  5'd1, 5'd5, 5'd9, 5'd5, 0, 1, 1, 1, 0, 0, 0, O_LD};
    vecs[2] = '{"ld_x0_ex",    5'd0, 5'd2, 5'd0, 5'd9, 1, 1, 1, 0, 0, 0, 0, O_RUN};
    vecs[3] = '{"use_rs1_off", 5'd5, 5'd2, 5'd5, 5'd5, 0, 1, 1, 1, 0, 0, 0, O_RUN};
    vecs[4] = '{"br_over_hzex",5'd5, 5'd2, 5'd5, 5'd0, 1, 0, 1, 0, 1, 0, 0, O_BR};
    vecs[5] = '{"mdu_done_now",5'd1, 5'd2, 5'd3, 5'd4, 0, 0, 0, 0, 0, 1, 1, O_RUN};
    vecs[6] = '{"no_load_mem", 5'd6, 5'd2, 5'd3, 5'd6, 1, 0, 0, 0, 0, 0, 0, O_RUN};
    vecs[7] = '{"br_over_hzm", 5'd6, 5'd2, 5'd3, 5'd6, 1, 0, 0, 1, 1, 0, 0, O_BR};
    vecs[8] = '{"hz_mem_rs1",  5'd6, 5'd2, 5'd6, 5'd6, 1, 0, 0, 1, 0, 0, 0, O_LD};
    vecs[9] = '{"ld_x0_mem",   5'd0, 5'd0, 5'd1, 5'd0, 1, 1, 0, 1, 0, 0, 0, O_RUN};

    set_idle();
    rst = 1'b1;
    exp_cnt = 32'd0;
    @(negedge clk);
    step("reset", O_RUN);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      step(vecs[i].name, vecs[i].exp);
    end

    // Load in EX feeding rs1: two stall cycles; branch/mdu ignored during LD_STALL.
    set_idle();
    EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
    step("ldex_c1", O_LD);
    set_idle();
    EX_branch_taken = 1'b1; EX_mdu_start = 1'b1;
    step("ldex_c2", O_LD);
    set_idle();
    step("ldex_c3", O_RUN);

    // MDU op held for four cycles, done on the fifth.
    set_idle();
    EX_mdu_start = 1'b1;
`ifdef STALL_CTRL_MDU_EN
    step("mdu_c1", O_MDU);
    EX_branch_taken = 1'b1;
    step("mdu_c2", O_MDU);
    EX_branch_taken = 1'b0;
    step("mdu_c3", O_MDU);
    step("mdu_c4", O_MDU);
    mdu_done = 1'b1;
    step("mdu_done", O_RUN);
`else
    step("mdu_c1", O_RUN);
    step("mdu_c2", O_RUN);
    step("mdu_c3", O_RUN);
    step("mdu_c4", O_RUN);
    mdu_done = 1'b1;
    step("mdu_done", O_RUN);
`endif
    set_idle();
    step("mdu_after", O_RUN);

    // Reset in the LD_STALL cycle leaves no residual bubble.
    EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_use_rs2 = 1'b1;
    step("rst_ld_c1", O_LD);
    set_idle();
    rst = 1'b1;
    step("rst_ld_c2", O_LD);
    rst = 1'b0;
    step("rst_ld_c3", O_RUN);

    // Saturation from a forced near-max count.
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    check_cnt("preload");
    MEM_MemRead = 1'b1; MEM_rd = 5'd9; ID_rs1 = 5'd9; ID_use_rs1 = 1'b1;
    step("sat_c1", O_LD);
    step("sat_c2", O_LD);
    step("sat_c3", O_LD);
    n_vec++;
    if (stall_count !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sat_final stall_count: got %h expected ffffffff", stall_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Ports SHALL be as follows, listed as name, direction, width, meaning:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- ID_rs1, ID_rs2  in  5 each  ID-stage source registers
- ID_use_rs1, ID_use_rs2  in  1 each  ID instruction reads that source
- EX_rd, MEM_rd  in  5 each  destinations in EX and MEM
- EX_MemRead, MEM_MemRead  in  1 each  stage holds a load
- EX_branch_taken  in  1  branch/jump resolved taken in EX
- EX_mdu_start  in  1  EX holds a multi-cycle mul/div op
- mdu_done  in  1  MDU result valid this cycle
- PC_write  out  1  PC may update
- IFID_write  out  1  IF/ID register may update
- IFID_flush  out  1  IF/ID becomes NOP
- IDEX_flush  out  1  ID/EX becomes bubble
- EX_hold  out  1  ID/EX and EX stage frozen
- EXMEM_flush  out  1  EX/MEM becomes bubble
- stall_count  out  32  cycles with PC_write=0

Function
REQ-003 Load data SHALL be forwardable only from WB (forward select 2), so a consumer needs two bubbles behind a load in EX and one bubble behind a load in MEM.
REQ-004 hz_ex SHALL be EX_MemRead & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)); hz_mem SHALL be the same expression using MEM_MemRead and MEM_rd.
REQ-005 FSM states SHALL be RUN, LD_STALL, and MDU_BUSY; the outputs SHALL be combinational from the state and the inputs.
REQ-006 A stall SHALL drive PC_write=0, IFID_write=0, and IDEX_flush=1.
REQ-007 In RUN, the priority SHALL be mdu > branch > hz_ex > hz_mem > none.
REQ-008 RUN with EX_mdu_start & !mdu_done SHALL drive PC_write=0, IFID_write=0, EX_hold=1, EXMEM_flush=1, and move to MDU_BUSY; EX_mdu_start & mdu_done in the same cycle SHALL cause no stall.
REQ-009 RUN with EX_branch_taken SHALL drive IFID_flush=1 and IDEX_flush=1, keep PC_write=1, stay in RUN, and override any hazard that cycle.
REQ-010 RUN with hz_ex SHALL stall and move to LD_STALL.
REQ-011 RUN with hz_mem only SHALL stall for that cycle and stay in RUN.
REQ-012 LD_STALL SHALL stall unconditionally and return to RUN; branch and mdu inputs SHALL be ignored in this state.
REQ-013 MDU_BUSY SHALL drive the same outputs as REQ-008 while mdu_done=0.
REQ-014 In MDU_BUSY, the cycle with mdu_done=1 SHALL release EX_hold (all outputs at their RUN defaults, no stall) and return to RUN; EX_branch_taken SHALL be ignored in this state.
REQ-015 Defaults (RUN, no event) SHALL be PC_write=1, IFID_write=1, all flush and hold outputs 0.
REQ-016 stall_count SHALL increment by 1 on each clock edge where PC_write=0 and rst=0, saturating at 32'hFFFF_FFFF with no wrap.

Reset
REQ-017 On a clock edge with rst=1, the state SHALL become RUN and stall_count SHALL become 0; the outputs then take the RUN defaults.
REQ-018 An rst asserted during LD_STALL or MDU_BUSY SHALL abandon the stall with no residual bubble after release.

Configuration
REQ-019 Macro STALL_CTRL_MDU_EN: when defined, the MDU_BUSY state and the mdu ports SHALL be functional as specified above.
REQ-020 When STALL_CTRL_MDU_EN is undefined, EX_mdu_start and mdu_done SHALL be ignored, MDU_BUSY SHALL be absent, and EX_hold and EXMEM_flush SHALL be tied to 0; the port list SHALL be unchanged.

Verification
REQ-021 Load x5 in EX, ID uses rs1=x5 -> 2 consecutive stall cycles (RUN->LD_STALL->RUN), stall_count +2.
REQ-022 Load x5 in MEM only, ID uses rs2=x5 -> 1 stall cycle; load to x0 in EX with ID_rs1=0 -> no stall; ID_use_rs1=0 with a matching register -> no stall.
REQ-023 EX_branch_taken=1 together with hz_ex=1 -> IFID_flush=1, IDEX_flush=1, PC_write=1, no LD_STALL entry.
REQ-024 STALL_CTRL_MDU_EN defined, EX_mdu_start=1 with mdu_done arriving 4 cycles later -> EX_hold=1 and EXMEM_flush=1 for 4 cycles, released on the done cycle, stall_count +4; same stimulus with the macro undefined -> no stall.
REQ-025 rst=1 in the cycle after entering LD_STALL -> next cycle in RUN with defaults and stall_count=0.
REQ-026 stall_count preloaded (forced) to 32'hFFFF_FFFE, then 3 stall cycles -> value stays at 32'hFFFF_FFFF.
